// File: rtl/fifo_srlp_pkg.sv
// fifo_srlp_pkg: shared fifo_srlp constants and depth/threshold helpers
package fifo_srlp_pkg;
  localparam int DEF_W = 6;
  localparam int DEF_AW = 4;
  localparam int DEF_AE = 1;
  function automatic int depth(input int aw);
    return 2 ** aw;
  endfunction
  function automatic int def_af(input int aw);
    return depth(aw) - 2;
  endfunction
endpackage

// File: rtl/fifo_srlp_srl.sv
// srl_array: reset-free shift register, d shifts into entry 0 on ce, y = entry a
module srl_array #(
  parameter int W = 6,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          ce,
  input  logic [W-1:0]  d,
  input  logic [AW-1:0] a,
  output logic [W-1:0]  y
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= d;
      for (int i = 1; i < 2**AW; i++) mem[i] <= mem[i-1];
    end
  end
  assign y = mem[a];
endmodule

// File: rtl/fifo_srlp.sv
// fifo_srlp: shift-register fifo; in clk rst clr pdi iv oe, out pdo ov empty full aempty afull cnt ovf udf
module fifo_srlp import fifo_srlp_pkg::*; #(
  parameter int W = DEF_W,
  parameter int AW = DEF_AW,
  parameter int AF = def_af(AW),
  parameter int AE = DEF_AE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [W-1:0]  pdi,
  input  logic          iv,
  input  logic          oe,
  output logic [W-1:0]  pdo,
  output logic          ov,
  output logic          empty,
  output logic          full,
  output logic          aempty,
  output logic          afull,
  output logic [AW:0]   cnt,
  output logic          ovf,
  output logic          udf
);
  localparam int DEPTH = depth(AW);
  localparam logic [AW:0] DV = DEPTH[AW:0];
  localparam logic [AW:0] AFV = AF[AW:0];
  localparam logic [AW:0] AEV = AE[AW:0];
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  if (AE < 0 || AE >= AF || AF > DEPTH) begin : g_bad_param
    $error("fifo_srlp: need 0 <= AE < AF <= DEPTH");
  end
  logic we;
  logic [AW:0] cm1;
  assign we = iv & ~full;
  assign ov = oe & ~empty;
  assign empty = cnt == '0;
  assign full = cnt == DV;
  assign afull = cnt >= AFV;
  assign aempty = cnt <= AEV;
  assign cm1 = cnt - ONE;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      cnt <= (we & ~ov) ? cnt + ONE : (ov & ~we) ? cm1 : cnt;
      ovf <= ovf | (iv & full);
      udf <= udf | (oe & empty);
    end
  end
  srl_array #(.W(W), .AW(AW)) u_srl (
    .clk(clk),
    .ce(we),
    .d(pdi),
    .a(cm1[AW-1:0]),
    .y(pdo)
  );
endmodule

// File: tb/tb_fifo_srlp.sv
// tb_fifo_srlp: randomized scoreboard bench for fifo_srlp against a queue model
module tb_fifo_srlp;
  typedef struct {
    int cnt;
    bit ovf;
    bit udf;
    bit ov;
  } st_t;
  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, iv = 1'b0, oe = 1'b0;
  logic [5:0] pdi = '0;
  logic [5:0] pdo;
  logic ov, empty, full, aempty, afull, ovf, udf;
  logic [4:0] cnt;
  int checks = 0;
  int errors = 0;
  logic [5:0] q[$];
  logic [5:0] exp_q[$];
  st_t st_q[$];
  bit mv = 0, ovfm = 0, udfm = 0;
  fifo_srlp dut (
    .clk(clk), .rst(rst), .clr(clr), .pdi(pdi), .iv(iv), .oe(oe),
    .pdo(pdo), .ov(ov), .empty(empty), .full(full), .aempty(aempty),
    .afull(afull), .cnt(cnt), .ovf(ovf), .udf(udf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit c, input bit i, input bit o, input logic [5:0] d);
    st_t s;
    bit ovx, fullx;
    @(posedge clk);
    #1;
    rst = r; clr = c; iv = i; oe = o; pdi = d;
    ovx = o && q.size() > 0;
    fullx = q.size() == 16;
    if (mv) begin
      s.cnt = q.size(); s.ovf = ovfm; s.udf = udfm; s.ov = ovx;
      st_q.push_back(s);
      if (ovx) exp_q.push_back(q[0]);
    end
    if (r || c) begin
      q.delete();
      ovfm = 0;
      udfm = 0;
      if (r) mv = 1;
    end else begin
      if (i && fullx) ovfm = 1;
      if (o && q.size() == 0) udfm = 1;
      if (ovx) void'(q.pop_front());
      if (i && !fullx) q.push_back(d);
    end
  endtask
  always @(negedge clk) begin
    st_t s;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("cnt", int'(cnt), s.cnt);
      chk("empty", int'(empty), int'(s.cnt == 0));
      chk("full", int'(full), int'(s.cnt == 16));
      chk("afull", int'(afull), int'(s.cnt >= 14));
      chk("aempty", int'(aempty), int'(s.cnt <= 1));
      chk("ovf", int'(ovf), int'(s.ovf));
      chk("udf", int'(udf), int'(s.udf));
      chk("ov", int'(ov), int'(s.ov));
      if (ov === 1'b1) begin
        if (exp_q.size() == 0) chk("pdo_unexpected_read", 1, 0);
        else chk("pdo", int'(pdo), int'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) cyc(0, 0, 1, 0, 6'(k));
    cyc(0, 0, 1, 0, 6'h3f);
    cyc(0, 0, 1, 1, 6'h3f);
    for (int k = 0; k < 16; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 6'h05);
    cyc(0, 0, 1, 0, 6'h06);
    cyc(0, 0, 1, 0, 6'h07);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 6'h08);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 6'h2a);
    cyc(0, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0, 6'(k + 20));
    cyc(1, 0, 1, 1, 6'h11);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      int wp;
      wp = ((k / 150) % 2 == 0) ? 75 : 30;
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 249) == 0,
          $urandom_range(0, 99) < wp, $urandom_range(0, 99) < 100 - wp,
          6'($urandom));
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
